// File: rtl/pipe_cpu.sv
// rtl/pipe_cpu.sv - 4-stage pipelined CPU (fetch, read/forward, execute, writeback)
module pipe_cpu #(
  parameter int D_BITS = 16,
  parameter int A_BITS = 8,
  parameter int R_BITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic [3*R_BITS+3:0]   instr,
  output logic [A_BITS-1:0]     pc,
  output logic                  halted,
  output logic                  wb_en,
  output logic [R_BITS-1:0]     wb_addr,
  output logic [D_BITS-1:0]     wb_data
);

  localparam int INSTR_BITS = 4 + 3*R_BITS;
  localparam int N_REGS     = 1 << R_BITS;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_OR    = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_LOADC = 4'd6;
  localparam logic [3:0] OP_JMP   = 4'd7;
  localparam logic [3:0] OP_JZ    = 4'd8;
  localparam logic [3:0] OP_HALT  = 4'd15;

  // F/R boundary: raw instruction word (all-zero word is a NOP)
  logic [INSTR_BITS-1:0] ir;
  logic [3:0]            ir_op;
  logic [R_BITS-1:0]     ir_dest, ir_s1, ir_s2;

  // R/E boundary: decoded fields plus resolved operand values
  logic [3:0]            rr_op;
  logic [R_BITS-1:0]     rr_dest, rr_s1, rr_s2;
  logic [D_BITS-1:0]     rr_a, rr_b;

  // E/W boundary: pending register write (addr/data zero when no write)
  logic                  er_en;
  logic [R_BITS-1:0]     er_addr;
  logic [D_BITS-1:0]     er_data;

  logic [D_BITS-1:0]     regs [N_REGS];

  // Execute-stage combinational results
  logic [D_BITS-1:0]     e_res;
  logic                  e_wr;
  logic                  e_fwd;
  logic                  e_taken;
  logic [A_BITS-1:0]     e_target;
  logic                  e_halt;

  // Read-stage operands after forwarding
  logic [D_BITS-1:0]     r_a, r_b;

  assign ir_op   = ir[INSTR_BITS-1 -: 4];
  assign ir_dest = ir[3*R_BITS-1 -: R_BITS];
  assign ir_s1   = ir[2*R_BITS-1 -: R_BITS];
  assign ir_s2   = ir[R_BITS-1:0];

  // Writes to r0 are dropped here so they never forward or reach the file
  assign e_fwd = e_wr && (rr_dest != '0);

  // Execute: ALU, constant load, branch resolution and halt detection
  always_comb begin
    e_res    = '0;
    e_wr     = 1'b0;
    e_taken  = 1'b0;
    e_target = '0;
    e_halt   = 1'b0;
    case (rr_op)
      OP_ADD:   begin e_res = rr_a + rr_b; e_wr = 1'b1; end
      OP_SUB:   begin e_res = rr_a - rr_b; e_wr = 1'b1; end
      OP_AND:   begin e_res = rr_a & rr_b; e_wr = 1'b1; end
      OP_OR:    begin e_res = rr_a | rr_b; e_wr = 1'b1; end
      OP_XOR:   begin e_res = rr_a ^ rr_b; e_wr = 1'b1; end
      OP_LOADC: begin e_res = D_BITS'({rr_s1, rr_s2}); e_wr = 1'b1; end
      OP_JMP:   begin e_taken = 1'b1; e_target = A_BITS'({rr_s1, rr_s2}); end
      OP_JZ:    begin e_taken = (rr_a == '0); e_target = A_BITS'({rr_dest, rr_s2}); end
      OP_HALT:  e_halt = 1'b1;
      default:  ;
    endcase
  end

  // Operand read: youngest producer first (E, then W, then register file)
  always_comb begin
    r_a = regs[ir_s1];
    if (ir_s1 == '0)                          r_a = '0;
    else if (e_fwd && (rr_dest == ir_s1))     r_a = e_res;
    else if (er_en && (er_addr == ir_s1))     r_a = er_data;
    r_b = regs[ir_s2];
    if (ir_s2 == '0)                          r_b = '0;
    else if (e_fwd && (rr_dest == ir_s2))     r_b = e_res;
    else if (er_en && (er_addr == ir_s2))     r_b = er_data;
  end

  // Register file: write-back at end of W, frozen while stalled
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
    end else if (!stall && er_en) begin
      regs[er_addr] <= er_data;
    end
  end

  // Pipeline advance: redirect/flush on taken branch, freeze on halt
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc      <= '0;
      halted  <= 1'b0;
      ir      <= '0;
      rr_op   <= OP_NOP;
      rr_dest <= '0;
      rr_s1   <= '0;
      rr_s2   <= '0;
      rr_a    <= '0;
      rr_b    <= '0;
      er_en   <= 1'b0;
      er_addr <= '0;
      er_data <= '0;
    end else if (!stall) begin
      er_en   <= e_fwd;
      er_addr <= e_fwd ? rr_dest : '0;
      er_data <= e_fwd ? e_res : '0;
      if (halted || e_halt || e_taken) begin
        if (halted || e_halt) halted <= 1'b1;
        else                  pc <= e_target;
        ir      <= '0;
        rr_op   <= OP_NOP;
        rr_dest <= '0;
        rr_s1   <= '0;
        rr_s2   <= '0;
        rr_a    <= '0;
        rr_b    <= '0;
      end else begin
        pc      <= pc + 1'b1;
        ir      <= instr;
        rr_op   <= ir_op;
        rr_dest <= ir_dest;
        rr_s1   <= ir_s1;
        rr_s2   <= ir_s2;
        rr_a    <= r_a;
        rr_b    <= r_b;
      end
    end
  end

  // Observation port is silent while in reset or stalled
  assign wb_en   = rst & ~stall & er_en;
  assign wb_addr = rst ? er_addr : '0;
  assign wb_data = rst ? er_data : '0;

endmodule

// File: tb/tb_pipe_cpu.sv
// tb/tb_pipe_cpu.sv - directed and randomized checks of pipe_cpu against an ISA-level model
module tb_pipe_cpu;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [12:0] instr;
  logic [7:0]  pc;
  logic        halted;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;

  logic [12:0] imem [256];
  assign instr = imem[pc];

  pipe_cpu #(.D_BITS(16), .A_BITS(8), .R_BITS(3)) dut (
    .clk(clk), .rst(rst), .stall(stall), .instr(instr), .pc(pc),
    .halted(halted), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  tr_pc   [64];
  logic        tr_en   [64];
  logic [2:0]  tr_addr [64];
  logic [15:0] tr_data [64];
  logic        tr_halt [64];

  localparam int NOP = 0, ADD = 1, SUB = 2, AND_ = 3, OR_ = 4, XOR_ = 5;
  localparam int LDC = 6, JMP = 7, JZ = 8, HALT = 15;

  function automatic logic [12:0] enc(input int op, input int d, input int s1, input int s2);
    return {op[3:0], d[2:0], s1[2:0], s2[2:0]};
  endfunction

  function automatic logic [31:0] wv(input int en, input int a, input int d);
    logic [31:0] v;
    v = {12'b0, en[0], a[2:0], d[15:0]};
    return v;
  endfunction

  function automatic logic [31:0] trw(input int c);
    return {12'b0, tr_en[c], tr_addr[c], tr_data[c]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [12:0] w);
    for (int i = 0; i < 256; i++) imem[i] = w;
  endtask

  // Entered and left at posedge+1
  task automatic do_reset(input int n);
    rst = 1'b0;
    stall = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      chk("rst_wb", {wb_en, wb_addr, wb_data}, 32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk("post_rst_pc", pc, 32'd0);
    chk("post_rst_halted", halted, 32'd0);
    chk("post_rst_wb", {wb_en, wb_addr, wb_data}, 32'd0);
  endtask

  task automatic run(input int n, input logic [63:0] smask);
    for (int c = 0; c < n; c++) begin
      stall = smask[c];
      #1;
      tr_pc[c] = pc; tr_en[c] = wb_en; tr_addr[c] = wb_addr;
      tr_data[c] = wb_data; tr_halt[c] = halted;
      @(posedge clk); #1;
    end
    stall = 1'b0;
  endtask

  task automatic run_random();
    int mreg [8];
    int expq [$];
    int mpc, nexec, ntaken, op, d, s1, s2, tgt, a, b, r, ucount;
    logic [12:0] ins;
    bit done, wr;
    fill(enc(HALT, 0, 0, 0));
    for (int i = 0; i < 48; i++) begin
      op = $urandom_range(0, 15);
      d  = $urandom_range(0, 7);
      s1 = $urandom_range(0, 7);
      s2 = $urandom_range(0, 7);
      if (op == JMP) begin
        tgt = $urandom_range(i + 1, 48); s1 = tgt / 8; s2 = tgt % 8;
      end else if (op == JZ) begin
        tgt = $urandom_range(i + 1, 48); d = tgt / 8; s2 = tgt % 8;
      end
      imem[i] = enc(op, d, s1, s2);
    end
    for (int i = 0; i < 8; i++) mreg[i] = 0;
    mpc = 0; nexec = 0; ntaken = 0;
    while (nexec < 300) begin
      ins = imem[mpc];
      nexec++;
      op = int'(ins[12:9]); d = int'(ins[8:6]); s1 = int'(ins[5:3]); s2 = int'(ins[2:0]);
      a = mreg[s1]; b = mreg[s2]; wr = 1'b1; r = 0;
      case (op)
        ADD:  r = (a + b) & 32'hFFFF;
        SUB:  r = (a - b) & 32'hFFFF;
        AND_: r = a & b;
        OR_:  r = a | b;
        XOR_: r = a ^ b;
        LDC:  r = s1 * 8 + s2;
        default: wr = 1'b0;
      endcase
      if (op == HALT) break;
      if (wr && d != 0) begin
        mreg[d] = r;
        expq.push_back(d * 65536 + r);
      end
      if (op == JMP) begin
        mpc = s1 * 8 + s2; ntaken++;
      end else if (op == JZ && a == 0) begin
        mpc = d * 8 + s2; ntaken++;
      end else begin
        mpc = (mpc + 1) % 256;
      end
    end
    do_reset(1);
    ucount = 0;
    done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      stall = ($urandom_range(0, 3) == 0);
      #1;
      if (halted) begin
        done = 1'b1;
        chk("rnd_halt_cycles", ucount, nexec + 2 + 2 * ntaken);
      end else begin
        if (stall) chk("rnd_stall_wb_en", wb_en, 32'd0);
        else if (wb_en) begin
          if (expq.size() == 0) chk("rnd_extra_write", {wb_addr, wb_data}, 32'hFFFFFFFF);
          else chk("rnd_write", {wb_addr, wb_data}, expq.pop_front());
        end
        if (!stall) ucount++;
      end
      @(posedge clk); #1;
    end
    stall = 1'b0;
    chk("rnd_halted_reached", done, 32'd1);
    chk("rnd_writes_left", expq.size(), 32'd0);
  endtask

  initial begin
    logic [7:0] pcs [7];
    rst = 1'b0;
    stall = 1'b0;
    fill(enc(NOP, 0, 0, 0));
    @(posedge clk); #1;

    // Back-to-back dependency through E and W forwarding
    fill(enc(NOP, 0, 0, 0));
    imem[0] = enc(LDC, 1, 0, 5); imem[1] = enc(LDC, 2, 0, 3);
    imem[2] = enc(ADD, 3, 1, 2); imem[3] = enc(HALT, 0, 0, 0);
    do_reset(2);
    run(8, 64'd0);
    chk("fwd_w0", trw(3), wv(1, 1, 5));
    chk("fwd_w1", trw(4), wv(1, 2, 3));
    chk("fwd_w2", trw(5), wv(1, 3, 8));

    // Subtraction to zero and modular wrap
    fill(enc(NOP, 0, 0, 0));
    imem[0] = enc(LDC, 1, 0, 0); imem[1] = enc(SUB, 2, 1, 1);
    imem[2] = enc(SUB, 3, 2, 1); imem[3] = enc(LDC, 4, 0, 1);
    imem[4] = enc(SUB, 5, 0, 4); imem[5] = enc(HALT, 0, 0, 0);
    do_reset(1);
    run(10, 64'd0);
    chk("sub_r2", trw(4), wv(1, 2, 0));
    chk("sub_r3", trw(5), wv(1, 3, 0));
    chk("sub_wrap", trw(7), wv(1, 5, 16'hFFFF));

    // JMP 20 from address 2
    fill(enc(NOP, 0, 0, 0));
    imem[0] = enc(LDC, 1, 0, 1); imem[1] = enc(LDC, 2, 0, 2);
    imem[2] = enc(JMP, 0, 2, 4); imem[3] = enc(LDC, 3, 0, 3);
    imem[4] = enc(LDC, 4, 0, 4); imem[20] = enc(LDC, 5, 0, 5);
    imem[21] = enc(HALT, 0, 0, 0);
    do_reset(1);
    run(10, 64'd0);
    pcs = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd20, 8'd21};
    for (int i = 0; i < 7; i++) chk($sformatf("jmp_pc%0d", i), tr_pc[i], pcs[i]);
    chk("jmp_nowr5", tr_en[5], 32'd0);
    chk("jmp_nowr6", tr_en[6], 32'd0);
    chk("jmp_nowr7", tr_en[7], 32'd0);
    chk("jmp_target_wr", trw(8), wv(1, 5, 5));

    // JZ not taken then taken
    fill(enc(NOP, 0, 0, 0));
    imem[0] = enc(LDC, 7, 0, 1); imem[1] = enc(JZ, 3, 7, 0);
    imem[2] = enc(LDC, 1, 1, 1); imem[3] = enc(LDC, 7, 0, 0);
    imem[4] = enc(JZ, 5, 7, 0); imem[5] = enc(LDC, 2, 0, 1);
    imem[6] = enc(LDC, 3, 0, 1); imem[40] = enc(LDC, 4, 0, 7);
    imem[41] = enc(HALT, 0, 0, 0);
    do_reset(1);
    run(12, 64'd0);
    chk("jz_nt_pc2", tr_pc[2], 32'd2);
    chk("jz_nt_pc6", tr_pc[6], 32'd6);
    chk("jz_nt_wr", trw(5), wv(1, 1, 9));
    chk("jz_t_pc7", tr_pc[7], 32'd40);
    chk("jz_t_bub8", tr_en[8], 32'd0);
    chk("jz_t_bub9", tr_en[9], 32'd0);
    chk("jz_t_wr10", trw(10), wv(1, 4, 7));

    // Stall for 3 cycles while a taken JZ sits in E
    fill(enc(NOP, 0, 0, 0));
    imem[0] = enc(LDC, 6, 1, 1); imem[1] = enc(JZ, 6, 0, 2);
    imem[2] = enc(LDC, 1, 0, 1); imem[3] = enc(LDC, 2, 0, 2);
    imem[50] = enc(LDC, 3, 0, 3); imem[51] = enc(HALT, 0, 0, 0);
    do_reset(1);
    run(12, 64'h38);
    for (int c = 3; c < 6; c++) begin
      chk($sformatf("stall_pc%0d", c), tr_pc[c], 32'd3);
      chk($sformatf("stall_wben%0d", c), tr_en[c], 32'd0);
    end
    chk("stall_resume_pc", tr_pc[6], 32'd3);
    chk("stall_resume_wr", trw(6), wv(1, 6, 9));
    chk("stall_redirect_pc", tr_pc[7], 32'd50);
    chk("stall_bub8", tr_en[8], 32'd0);
    chk("stall_target_wr", trw(10), wv(1, 3, 3));

    // HALT at 4, then a one-cycle reset
    fill(enc(NOP, 0, 0, 0));
    imem[0] = enc(LDC, 1, 0, 7); imem[1] = enc(LDC, 2, 1, 0);
    imem[2] = enc(ADD, 3, 1, 2); imem[4] = enc(HALT, 0, 0, 0);
    imem[5] = enc(LDC, 4, 0, 1); imem[6] = enc(LDC, 5, 0, 1);
    do_reset(1);
    run(11, 64'd0);
    chk("halt_add", trw(5), wv(1, 3, 15));
    chk("halt_not_yet", tr_halt[6], 32'd0);
    for (int c = 7; c < 11; c++) begin
      chk($sformatf("halt_flag%0d", c), tr_halt[c], 32'd1);
      chk($sformatf("halt_pc%0d", c), tr_pc[c], 32'd6);
      chk($sformatf("halt_nowr%0d", c), tr_en[c], 32'd0);
    end
    fill(enc(NOP, 0, 0, 0));
    imem[0] = enc(ADD, 4, 1, 2); imem[1] = enc(OR_, 5, 3, 0);
    imem[2] = enc(HALT, 0, 0, 0);
    do_reset(1);
    run(6, 64'd0);
    chk("reset_regs_r4", trw(3), wv(1, 4, 0));
    chk("reset_regs_r5", trw(4), wv(1, 5, 0));

    // Randomized programs with random stalls against the ISA model
    for (int it = 0; it < 20; it++) run_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_cpu.md
PIPE_CPU -- requirements
Module: pipe_cpu

Interface
REQ-001 The block SHALL have parameter D_BITS, default 16, meaning datapath and register width.
REQ-002 The block SHALL have parameter A_BITS, default 8, meaning PC and instruction-address width.
REQ-003 The block SHALL have parameter R_BITS, default 3, meaning register-index width (2^R_BITS registers).
REQ-004 The block SHALL derive instruction width INSTR_BITS = 4 + 3*R_BITS internally: opcode[top 4], dest, src1, src2 (R_BITS each, MSB to LSB).
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 stall  input  1  1 = freeze entire pipeline this cycle.
REQ-008 instr  input  INSTR_BITS  instruction word at address pc, valid combinationally in the same cycle.
REQ-009 pc  output  A_BITS  fetch address.
REQ-010 halted  output  1  sticky, set by HALT.
REQ-011 wb_en, wb_addr, wb_data  output  1/R_BITS/D_BITS  register-file write this cycle (observation port).

Function
REQ-012 The block SHALL be a 4-stage pipeline: F (latch instr into IR), R (register read plus forwarding into RR), E (ALU/branch into ER), W (register-file write at end of cycle).
REQ-013 An instruction fetched at cycle k SHALL be in R at k+1, E at k+2, W at k+3; its register write SHALL be visible to reads from cycle k+4.
REQ-014 Opcodes SHALL decode as: 0 NOP; 1 ADD; 2 SUB (src1-src2); 3 AND; 4 OR; 5 XOR; 6 LOADC (dest = zero-extended {src1,src2}); 7 JMP (pc = {src1,src2}); 8 JZ (if src1 value == 0, pc = {dest,src2}); 15 HALT; 9-14 decode as NOP.
REQ-015 Arithmetic SHALL be modulo 2^D_BITS; no flags.
REQ-016 Jump targets SHALL be zero-extended or truncated to A_BITS.
REQ-017 Register 0 SHALL read as zero; writes to it SHALL be discarded (wb_en=0) and never forwarded.
REQ-018 Operand source priority in R SHALL be: E-stage result, then W-stage result, then register file; only ALU and LOADC results SHALL forward. No data-hazard stalls.
REQ-019 pc SHALL increment by 1 per non-stalled cycle, wrapping from 2^A_BITS-1 to 0.
REQ-020 A taken JMP/JZ in E SHALL load pc with the target and replace IR and RR contents with NOP on the same edge; penalty 2 cycles. A not-taken JZ SHALL have no penalty.
REQ-021 HALT in E SHALL set halted, freeze pc, flush IR and RR to NOP; the instruction already in ER SHALL still complete; halted SHALL remain 1 and the pipeline SHALL remain idle until reset.
REQ-022 With stall=1, pc, IR, RR, ER, halted and the register file SHALL hold, and wb_en SHALL be 0; held actions resume on the first cycle with stall=0.
REQ-023 Stall and a taken branch in E in the same cycle: stall wins, and the branch SHALL take effect on the first unstalled cycle.

Reset
REQ-024 With rst=0 at a rising edge: pc=0, IR/RR/ER=NOP, all registers=0, halted=0; reset SHALL override stall and HALT.
REQ-025 Outputs during and immediately after reset: wb_en=0, wb_addr=0, wb_data=0; the first fetch SHALL be address 0 on the first edge with rst=1.
REQ-026 Reset asserted mid-instruction SHALL discard all in-flight instructions; no write SHALL occur on the reset edge.

Verification (R_BITS=3, D_BITS=16, A_BITS=8)
REQ-027 LOADC r1,5; LOADC r2,3; ADD r3,r1,r2 back-to-back -> wb writes r1=5, r2=3, then r3=8 on consecutive cycles (exercises E and W forwarding).
REQ-028 LOADC r1,0; SUB r2,r1,r1; SUB r3,r2,r1 -> r2=0, then r3=0; a further LOADC r4,1 followed by SUB r5,r0,r4 -> r5=0xFFFF (wrap).
REQ-029 JMP 20 at address 2 -> instructions at 3 and 4 produce no write; the next fetch after them is address 20; pc sequence 0,1,2,3,4,20,21.
REQ-030 LOADC r7,1 then JZ r7 -> not taken, no bubbles; LOADC r7,0 then JZ r7 -> taken with 2 bubbles.
REQ-031 Stall held for 3 cycles while a taken JZ is in E -> pc, wb_en=0 and all state frozen during the stall; the branch redirects on the first unstalled cycle.
REQ-032 HALT at address 4, then rst=0 for 1 cycle -> halted=1 from the cycle after HALT reaches E, pc frozen; after reset, halted=0, pc=0, all registers read 0.
